// File: rtl/lift_call_scheduler.sv
// rtl/lift_call_scheduler.sv - SCAN-ordered call scheduler for a 4-floor lift
// Optional stall-timeout fault is enabled by defining LIFT_SCHED_TIMEOUT_EN.
module lift_call_scheduler #(
  parameter int unsigned NFLOORS     = 4,
  parameter int unsigned DWELL_CYC   = 3,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NFLOORS-1:0] call_req,
  input  logic [1:0]         lift_state,
  output logic [1:0]         floor,
  output logic [NFLOORS-1:0] pending,
  output logic               dir,
  output logic               busy,
  output logic               door_open,
  output logic               fault
);

  localparam int unsigned DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYC - 1);

  if (DWELL_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("DWELL_CYC and TIMEOUT_CYC must both be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MOVE  = 2'd1,
    ST_DWELL = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          floor_q, floor_d;
  logic [NFLOORS-1:0]  pending_q, pending_d;
  logic                dir_q, dir_d;
  logic [DW-1:0]       dwell_q, dwell_d;
  logic [NFLOORS-1:0]  clr;
  logic [NFLOORS-1:0]  ls_onehot;
  logic                up_any, dn_any;
  logic [1:0]          up_tgt, dn_tgt;
  logic                fault_blk;

  assign ls_onehot = {{(NFLOORS-1){1'b0}}, 1'b1} << lift_state;

  // Descending scan leaves the lowest floor above; ascending leaves the highest below.
  always_comb begin
    up_any = 1'b0;
    up_tgt = 2'd0;
    dn_any = 1'b0;
    dn_tgt = 2'd0;
    for (int i = NFLOORS - 1; i >= 0; i--) begin
      if (pending_q[i] && (i > int'(lift_state))) begin
        up_any = 1'b1;
        up_tgt = 2'(i);
      end
    end
    for (int i = 0; i < NFLOORS; i++) begin
      if (pending_q[i] && (i < int'(lift_state))) begin
        dn_any = 1'b1;
        dn_tgt = 2'(i);
      end
    end
  end

`ifdef LIFT_SCHED_TIMEOUT_EN
  localparam int unsigned STW = $clog2(TIMEOUT_CYC + 1);
  logic [STW-1:0] stall_q, stall_d;
  logic [1:0]     last_ls_q;
  logic           fault_q, fault_d;
  assign fault_blk = fault_q;
  assign fault     = fault_q;
`else
  assign fault_blk = 1'b0;
  assign fault     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    dwell_d = dwell_q;
    clr     = '0;
`ifdef LIFT_SCHED_TIMEOUT_EN
    stall_d = stall_q;
    fault_d = fault_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pending_q != '0) begin
          if (pending_q[lift_state]) begin
            state_d = ST_DWELL;
            dwell_d = DWELL_LOAD;
            clr     = ls_onehot;
          end else if (!fault_blk) begin
            if (up_any && (dir_q || !dn_any)) begin
              dir_d   = 1'b1;
              floor_d = up_tgt;
              state_d = ST_MOVE;
            end else if (dn_any) begin
              dir_d   = 1'b0;
              floor_d = dn_tgt;
              state_d = ST_MOVE;
            end
`ifdef LIFT_SCHED_TIMEOUT_EN
            stall_d = '0;
`endif
          end
        end
      end
      ST_MOVE: begin
        if (lift_state == floor_q) begin
          state_d = ST_DWELL;
          dwell_d = DWELL_LOAD;
          clr     = ls_onehot;
        end else begin
          // Retarget only ever pulls the target nearer along the current sweep.
          if (dir_q && up_any && (up_tgt < floor_q)) begin
            floor_d = up_tgt;
          end else if (!dir_q && dn_any && (dn_tgt > floor_q)) begin
            floor_d = dn_tgt;
          end
`ifdef LIFT_SCHED_TIMEOUT_EN
          if (lift_state != last_ls_q) begin
            stall_d = '0;
          end else if (stall_q == STW'(TIMEOUT_CYC - 1)) begin
            fault_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            stall_d = stall_q + 1'b1;
          end
`endif
        end
      end
      ST_DWELL: begin
        clr = ls_onehot;
        if (dwell_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          dwell_d = dwell_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pending_d = (pending_q | call_req) & ~clr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      floor_q   <= 2'd0;
      pending_q <= '0;
      dir_q     <= 1'b1;
      dwell_q   <= '0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      pending_q <= pending_d;
      dir_q     <= dir_d;
      dwell_q   <= dwell_d;
    end
  end

`ifdef LIFT_SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q   <= '0;
      last_ls_q <= 2'd0;
      fault_q   <= 1'b0;
    end else begin
      stall_q   <= stall_d;
      last_ls_q <= lift_state;
      fault_q   <= fault_d;
    end
  end
`endif

  assign floor     = floor_q;
  assign pending   = pending_q;
  assign dir       = dir_q;
  assign busy      = (state_q != ST_IDLE);
  assign door_open = (state_q == ST_DWELL);

endmodule

// File: tb/tb_lift_call_scheduler.sv
// tb/tb_lift_call_scheduler.sv - randomized bench with reference model for lift_call_scheduler
module tb_lift_call_scheduler;

  localparam int DWELL = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] call_req;
  logic [1:0] lift_state;
  logic [1:0] floor;
  logic [3:0] pending;
  logic       dir;
  logic       busy;
  logic       door_open;
  logic       fault;

  always #5 clk = ~clk;

  lift_call_scheduler #(.NFLOORS(4), .DWELL_CYC(DWELL), .TIMEOUT_CYC(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .call_req   (call_req),
    .lift_state (lift_state),
    .floor      (floor),
    .pending    (pending),
    .dir        (dir),
    .busy       (busy),
    .door_open  (door_open),
    .fault      (fault)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: the lift is either waiting, travelling, or holding its doors.
  localparam int WAITING = 0, TRAVEL = 1, DOORS = 2;
  int       m_mode;
  int       m_floor;
  bit [3:0] m_pend;
  bit       m_dir;
  int       m_left;

  function automatic int nearest_above(bit [3:0] p, int here);
    for (int f = here + 1; f < 4; f++) if (p[f]) return f;
    return -1;
  endfunction

  function automatic int nearest_below(bit [3:0] p, int here);
    for (int f = here - 1; f >= 0; f--) if (p[f]) return f;
    return -1;
  endfunction

  task automatic model_step();
    int here, up, dn;
    bit served;
    bit [3:0] calls;
    if (rst) begin
      m_mode = WAITING; m_floor = 0; m_pend = 0; m_dir = 1; m_left = 0;
      return;
    end
    here   = int'(lift_state);
    up     = nearest_above(m_pend, here);
    dn     = nearest_below(m_pend, here);
    served = 0;
    calls  = call_req;
    if (m_mode == WAITING) begin
      if (m_pend[here]) begin
        m_mode = DOORS; m_left = DWELL; served = 1;
      end else if (up >= 0 && (m_dir || dn < 0)) begin
        m_dir = 1; m_floor = up; m_mode = TRAVEL;
      end else if (dn >= 0) begin
        m_dir = 0; m_floor = dn; m_mode = TRAVEL;
      end
    end else if (m_mode == TRAVEL) begin
      if (here == m_floor) begin
        m_mode = DOORS; m_left = DWELL; served = 1;
      end else if (m_dir && up >= 0 && up < m_floor) begin
        m_floor = up;
      end else if (!m_dir && dn >= 0 && dn > m_floor) begin
        m_floor = dn;
      end
    end else begin
      served = 1;
      m_left--;
      if (m_left == 0) m_mode = WAITING;
    end
    m_pend = m_pend | calls;
    if (served) m_pend[here] = 1'b0;
  endtask

  task automatic check_all();
    check_eq("floor", floor, m_floor);
    check_eq("pending", pending, m_pend);
    check_eq("dir", dir, m_dir);
    check_eq("busy", busy, m_mode != WAITING);
    check_eq("door_open", door_open, m_mode == DOORS);
    check_eq("fault", fault, 0);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst = 1'b1; call_req = 4'b0; lift_state = 2'd0;
    step();
    step();
    check_eq("rst_floor", floor, 0);
    check_eq("rst_dir", dir, 1);
    check_eq("rst_busy", busy, 0);
    rst = 1'b0;
    step();

    // Call at the top floor, retarget to floor 2 on the way up.
    call_req = 4'b1000; step();
    check_eq("s1_pending", pending, 4'b1000);
    check_eq("s1_idle", busy, 0);
    call_req = 4'b0000; step();
    check_eq("s1_floor", floor, 3);
    check_eq("s1_busy", busy, 1);
    lift_state = 2'd1; step();
    call_req = 4'b0100; step();
    call_req = 4'b0000; step();
    check_eq("s1_retarget", floor, 2);
    lift_state = 2'd2; step();
    check_eq("s1_door0", door_open, 1);
    check_eq("s1_pend_served", pending, 4'b1000);
    step(); check_eq("s1_door1", door_open, 1);
    step(); check_eq("s1_door2", door_open, 1);
    step(); check_eq("s1_idle_gap", busy, 0);
    step(); check_eq("s1_next_floor", floor, 3);

    // Sweep finishes upward before reversing to floor 0.
    call_req = 4'b0001; step();
    call_req = 4'b0000; lift_state = 2'd3; step();
    check_eq("s2_pending", pending, 4'b0001);
    repeat (4) step();
    check_eq("s2_dir", dir, 0);
    check_eq("s2_floor", floor, 0);

    // Reset mid-move.
    lift_state = 2'd2; step();
    call_req = 4'b1010; step();
    call_req = 4'b0000; rst = 1'b1; step();
    check_eq("s3_floor", floor, 0);
    check_eq("s3_pending", pending, 0);
    check_eq("s3_busy", busy, 0);
    check_eq("s3_door", door_open, 0);
    check_eq("s3_dir", dir, 1);
    rst = 1'b0;

    // Call at the current floor opens the doors without moving.
    lift_state = 2'd1; call_req = 4'b0010; step();
    check_eq("s4_pending", pending, 4'b0010);
    step();
    check_eq("s4_door", door_open, 1);
    check_eq("s4_cleared", pending, 0);
    check_eq("s4_floor", floor, 0);
    step(); step();
    check_eq("s4_absorbed", pending, 0);
    call_req = 4'b0000; step();
    check_eq("s4_idle", busy, 0);

    // Randomized traffic with a simple lift emulator.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst = ($urandom_range(0, 399) == 0);
      call_req = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 59) == 0) begin
        lift_state = 2'($urandom);
      end else if (!door_open && busy && lift_state != floor && $urandom_range(0, 1) == 0) begin
        lift_state = (lift_state < floor) ? lift_state + 2'd1 : lift_state - 2'd1;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
